sha256_digest_uart_tx: RTL

Transmit-side companion to the UART command receiver in the SHA-256 processor top level. Accepts a completed 256-bit digest from the hash core over a valid/ready handshake and serializes it onto uart_tx as 8N1 frames. The output is either 32 raw bytes or a 66-character ASCII hex line, selected at compile time. Sits between the SHA-256 core's done/digest outputs and the board's uart_tx pin.

---
 rtl/sha256_digest_uart_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sha256_digest_uart_tx.sv
// Serialises a 256-bit SHA-256 digest onto an 8N1 UART line, MSB byte first.
// Define SHA256_TX_HEX_ASCII_EN to send a 64-char lowercase hex line plus CR/LF instead of 32 raw bytes.
module sha256_digest_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned DIGEST_BITS  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   digest_valid,
    input  logic [DIGEST_BITS-1:0] digest,
    output logic                   digest_ready,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   done
);

`ifdef SHA256_TX_HEX_ASCII_EN
    localparam int unsigned NUM_FRAMES = 66;
    localparam int unsigned SHIFT_STEP = 4;
    // 66 frames do not fit the 6-bit raw-mode count, so hex mode carries one more bit
    localparam int unsigned BYTE_W     = 7;
`else
    localparam int unsigned NUM_FRAMES = 32;
    localparam int unsigned SHIFT_STEP = 8;
    localparam int unsigned BYTE_W     = 6;
`endif
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [2:0]           nxt_bit;
    logic [BYTE_W-1:0]    byte_cnt, byte_cnt_n;
    logic [DIGEST_BITS-1:0] shreg;
    logic [7:0]           cur_char;
    logic                 bit_end;
    logic                 tx_n;
    logic                 done_n;
    logic                 load;
    logic                 shift;

`ifdef SHA256_TX_HEX_ASCII_EN
    logic [3:0] nibble;

    always_comb begin
        nibble = shreg[DIGEST_BITS-1 -: 4];
        if (byte_cnt == BYTE_W'(NUM_FRAMES - 2)) begin
            cur_char = 8'h0D;
        end else if (byte_cnt == BYTE_LAST) begin
            cur_char = 8'h0A;
        end else if (nibble < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nibble};
        end else begin
            cur_char = 8'h57 + {4'h0, nibble};
        end
    end
`else
    always_comb begin
        cur_char = shreg[DIGEST_BITS-1 -: 8];
    end
`endif

    assign bit_end      = (clk_cnt == BIT_LAST);
    assign nxt_bit      = bit_idx + 3'd1;
    assign digest_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    // tx_n is the line level for the next cycle, so uart_tx comes straight from a flop
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        byte_cnt_n = byte_cnt;
        tx_n       = uart_tx;
        done_n     = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (digest_valid) begin
                    load       = 1'b1;
                    state_n    = START;
                    clk_cnt_n  = '0;
                    bit_idx_n  = '0;
                    byte_cnt_n = '0;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    tx_n      = cur_char[0];
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = nxt_bit;
                        tx_n      = cur_char[nxt_bit];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (byte_cnt == BYTE_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        tx_n    = 1'b1;
                    end else begin
                        state_n    = START;
                        byte_cnt_n = byte_cnt + 1'b1;
                        shift      = 1'b1;
                        tx_n       = 1'b0;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_cnt <= byte_cnt_n;
            uart_tx  <= tx_n;
            done     <= done_n;
            if (load) begin
                shreg <= digest;
            end else if (shift) begin
                shreg <= shreg << SHIFT_STEP;
            end
        end
    end

endmodule
